systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Operand staging and skew stage directly upstream of the NxN systolic array wrapper.
- Buffers one NxN activation matrix A and one NxN weight matrix W, loaded one row per beat.
- Hands the matrices to the array using the array's start/ready/done handshake.
- Streams both matrices as diagonally skewed 8-bit lanes on flattened buses that connect to the array's a_in/w_in.

Parameters:
- N, 4, array dimension (rows, columns and lanes).
- DW, 8, element width in bits. The flattened bus width is DW*N.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low (rst=0 resets on the clk rising edge).
- ld_valid  in  1  load beat valid.
- ld_ready  out  1  load beat accepted when ld_valid and ld_ready are both high.
- ld_sel  in  1  target matrix: 0 = A, 1 = W.
- ld_data  in  DW*N  one matrix row; element c is at bits [DW*c+DW-1 : DW*c].
- go  in  1  request to start a multiply.
- busy  out  1  high whenever state != LOAD.
- arr_start  out  1  one-cycle start pulse to the array.
- arr_ready  in  1  array idle and able to accept start.
- arr_done  in  1  array finished, single-cycle pulse.
- a_out  out  DW*N  skewed activation lanes; lane i is at bits [DW*i+DW-1 : DW*i].
- w_out  out  DW*N  skewed weight lanes, same lane layout.
- done  out  1  one-cycle pulse: operation complete and feeder reloadable.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=LOAD; row counters cntA=cntW=0; stream counter k=0; arr_done latch cleared.
  - Outputs: arr_start=0, busy=0, done=0, a_out=0, w_out=0.
  - Buffer contents are don't-care.
  - Reset mid-operation (any state) aborts immediately; there is no further arr_start or done.
- Row storage: buffers Amem[N][N] and Wmem[N][N].
- LOAD state:
  - ld_ready = (ld_sel ? cntW<N : cntA<N). It is combinational on ld_sel and 0 in all other states.
  - On an accepted beat, ld_data is written to row cnt of the selected matrix, and that matrix's count increments. Counts saturate at N; there is no wrap.
  - go is honoured only when cntA==N and cntW==N, and then moves to ARM. Otherwise go is ignored and not remembered.
  - A ld_valid and go in the same cycle cannot conflict: go needs both matrices full, which forces ld_ready=0.
- ARM state: wait for arr_ready=1.
  - In the cycle arr_ready=1 is sampled, the registered arr_start is 1 for exactly the next cycle.
  - The state moves to STREAM together with that pulse, with k=0. The first data lane is therefore valid in the same cycle as arr_start.
- STREAM state: lasts 2N-1 cycles, k = 0 .. 2N-2. Outputs are registered and valid during these cycles.
  - a_out lane i = Amem[i][k-i] if 0 <= k-i < N, else 0. Row i enters delayed by i.
  - w_out lane j = Wmem[k-j][j] if 0 <= k-j < N, else 0. Column j enters delayed by j.
  - After k=2N-2 the state goes to DRAIN, and a_out/w_out return to 0.
  - An arr_done pulse seen during ARM or STREAM is latched and not lost.
- DRAIN state: wait for arr_done, or the latch already set.
  - done=1 for one cycle, in the cycle after arr_done is sampled. If the latch was set, done fires on the first DRAIN cycle.
  - On that cycle: cntA=cntW=0, the latch is cleared, and the state returns to LOAD.
  - Buffer data is retained, but a full reload of N rows per matrix is required before the next go.
- a_out and w_out are 0 in every state except STREAM.
- Total latency from go (both matrices full, arr_ready=1) to arr_start is 1 cycle.
- Element values are passed through unmodified; no arithmetic is performed.

Test Plan:
- Reset and idle:
  - Stimulus: hold rst=0 for 2 cycles with ld_valid=1 and go=1.
  - Required: all outputs 0, ld_ready=1 after release, no arr_start.
- Load and skew:
  - Stimulus: load A rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, W = identity; go with arr_ready=1.
  - Required: arr_start one cycle later.
  - a_out lanes[0..3]:
    - k=0: {1,0,0,0}
    - k=1: {2,5,0,0}
    - k=3: {4,7,10,13}
    - k=6: {0,0,0,16}
  - w_out lane j equals 1 only at k=2j, else 0.
- Early go and overflow:
  - Stimulus: go after only 3 A rows → ignored, busy=0.
  - Stimulus: a 5th beat to A (after the 4th) → ld_ready=0 while ld_sel=0; ld_sel=1 beats are still accepted.
- arr_ready backpressure:
  - Stimulus: arr_ready=0 for 5 cycles after go.
  - Required: busy=1, no arr_start, lanes 0; arr_start occurs one cycle after arr_ready rises.
- Done handling:
  - Stimulus: arr_done arrives 3 cycles after STREAM ends → done pulses the following cycle.
  - Stimulus: arr_done during STREAM (k=2) → done on the first DRAIN cycle.
  - In both cases the counts are cleared and ld_ready=1 afterwards.
- Mid-stream reset:
  - Stimulus: rst=0 at k=3.
  - Required: next cycle state=LOAD, lanes 0, no done pulse; a subsequent full load and go works normally.

Source files
------------

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_feeder
// Purpose  : Operand staging and diagonal skew stage in front of an NxN
//            systolic array. Buffers one activation matrix A and one weight
//            matrix W (one row per load beat), starts the array through its
//            start/ready/done handshake, then streams A rows and W columns
//            as skewed DW-bit lanes.
// Ports    : clk, rst (sync, active-low)
//            ld_valid/ld_ready/ld_sel/ld_data : row load channel (sel 0=A, 1=W)
//            go                               : start request (needs A and W full)
//            busy                             : feeder not in LOAD
//            arr_start/arr_ready/arr_done     : array handshake
//            a_out/w_out                      : skewed lanes, lane i at [DW*i +: DW]
//            done                             : one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module systolic_feeder #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic            ld_sel,
  input  logic [DW*N-1:0] ld_data,
  input  logic            go,
  output logic            busy,
  output logic            arr_start,
  input  logic            arr_ready,
  input  logic            arr_done,
  output logic [DW*N-1:0] a_out,
  output logic [DW*N-1:0] w_out,
  output logic            done
);

  localparam int KW = $clog2(2*N-1);
  localparam int CW = $clog2(N+1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST   = KW'(2*N-2);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt_a, r_cnt_w, w_cnt_a_nxt, w_cnt_w_nxt;
  logic [KW-1:0]   r_k, w_k_nxt;
  logic            r_seen, w_seen_nxt;
  logic            w_start_nxt;
  logic            w_accept, w_full;
  logic [DW-1:0]   r_amem [N][N];
  logic [DW-1:0]   r_wmem [N][N];
  logic [DW*N-1:0] w_a_lanes, w_w_lanes;

  assign ld_ready = (r_state == LOAD) &&
                    (ld_sel ? (r_cnt_w < CNT_FULL) : (r_cnt_a < CNT_FULL));
  assign w_accept = ld_valid && ld_ready;
  assign w_full   = (r_cnt_a == CNT_FULL) && (r_cnt_w == CNT_FULL);
  assign busy     = (r_state != LOAD);
  // A latched arr_done in DRAIN is the completion condition; the cycle it is
  // visible there is the done cycle, and the FSM leaves DRAIN at its end.
  assign done     = (r_state == DRAIN) && r_seen;

  // Row buffers: contents need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int c = 0; c < N; c++) begin
        if (ld_sel) r_wmem[r_cnt_w[IW-1:0]][c] <= ld_data[DW*c +: DW];
        else        r_amem[r_cnt_a[IW-1:0]][c] <= ld_data[DW*c +: DW];
      end
    end
  end

  // Lane values for the stream index of the coming cycle, so the registered
  // outputs line up with k. Lane i carries A row i and W column i, each
  // delayed by i cycles.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [KW-1:0] w_off;
    logic [DW-1:0] w_a_el, w_w_el;

    assign w_off = w_k_nxt - KW'(i);

    always_comb begin
      w_a_el = '0;
      w_w_el = '0;
      if ((w_k_nxt >= KW'(i)) && (w_off < KW'(N))) begin
        w_a_el = r_amem[i][w_off[IW-1:0]];
        w_w_el = r_wmem[w_off[IW-1:0]][i];
      end
    end

    assign w_a_lanes[DW*i +: DW] = w_a_el;
    assign w_w_lanes[DW*i +: DW] = w_w_el;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_a_nxt = r_cnt_a;
    w_cnt_w_nxt = r_cnt_w;
    w_k_nxt     = r_k;
    w_seen_nxt  = r_seen;
    w_start_nxt = 1'b0;

    if (w_accept) begin
      if (ld_sel) w_cnt_w_nxt = r_cnt_w + CW'(1);
      else        w_cnt_a_nxt = r_cnt_a + CW'(1);
    end

    case (r_state)
      LOAD: begin
        // With the array already ready, skip ARM so start follows go by one cycle.
        if (go && w_full) begin
          if (arr_ready) begin
            w_state_nxt = STREAM;
            w_k_nxt     = '0;
            w_start_nxt = 1'b1;
          end else begin
            w_state_nxt = ARM;
          end
        end
      end
      ARM: begin
        if (arr_done) w_seen_nxt = 1'b1;
        if (arr_ready) begin
          w_state_nxt = STREAM;
          w_k_nxt     = '0;
          w_start_nxt = 1'b1;
        end
      end
      STREAM: begin
        if (arr_done) w_seen_nxt = 1'b1;
        if (r_k == K_LAST) w_state_nxt = DRAIN;
        else               w_k_nxt     = r_k + KW'(1);
      end
      DRAIN: begin
        if (r_seen) begin
          w_state_nxt = LOAD;
          w_cnt_a_nxt = '0;
          w_cnt_w_nxt = '0;
          w_seen_nxt  = 1'b0;
        end else if (arr_done) begin
          w_seen_nxt = 1'b1;
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= LOAD;
      r_cnt_a   <= '0;
      r_cnt_w   <= '0;
      r_k       <= '0;
      r_seen    <= 1'b0;
      arr_start <= 1'b0;
      a_out     <= '0;
      w_out     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt_a   <= w_cnt_a_nxt;
      r_cnt_w   <= w_cnt_w_nxt;
      r_k       <= w_k_nxt;
      r_seen    <= w_seen_nxt;
      arr_start <= w_start_nxt;
      a_out     <= (w_state_nxt == STREAM) ? w_a_lanes : '0;
      w_out     <= (w_state_nxt == STREAM) ? w_w_lanes : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_feeder
// Purpose  : Self-checking bench for systolic_feeder. A timeline model
//            (cycle stamps for start and completion, lane values from the
//            loaded matrices) is compared every cycle, plus literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            ld_valid;
  logic            ld_ready;
  logic            ld_sel;
  logic [DW*N-1:0] ld_data;
  logic            go;
  logic            busy;
  logic            arr_start;
  logic            arr_ready;
  logic            arr_done;
  logic [DW*N-1:0] a_out;
  logic [DW*N-1:0] w_out;
  logic            done;

  int checks = 0;
  int errors = 0;

  systolic_feeder #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_sel    (ld_sel),
    .ld_data   (ld_data),
    .go        (go),
    .busy      (busy),
    .arr_start (arr_start),
    .arr_ready (arr_ready),
    .arr_done  (arr_done),
    .a_out     (a_out),
    .w_out     (w_out),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  int            cyc     = 0;   // index of the current clock cycle
  logic [DW-1:0] m_a [N][N];
  logic [DW-1:0] m_w [N][N];
  int            m_ca    = 0;
  int            m_cw    = 0;
  bit            m_busy  = 1'b0;
  int            m_start = -1;  // cycle holding arr_start / stream index 0
  int            m_seen  = -1;  // cycle in which the first arr_done was seen
  logic          exp_ldr;

  assign exp_ldr = !m_busy && (ld_sel ? (m_cw < N) : (m_ca < N));

  // Completion: cycle after arr_done, but never before the first cycle after
  // the 2N-1 stream cycles.
  function automatic int done_at();
    int a, b;
    a = m_seen + 1;
    b = m_start + 2*N - 1;
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DW*N-1:0] lanes_a(input int t);
    logic [DW*N-1:0] r;
    r = '0;
    if (t >= 0 && t <= 2*N-2)
      for (int i = 0; i < N; i++)
        if (t - i >= 0 && t - i < N) r[DW*i +: DW] = m_a[i][t-i];
    return r;
  endfunction

  function automatic logic [DW*N-1:0] lanes_w(input int t);
    logic [DW*N-1:0] r;
    r = '0;
    if (t >= 0 && t <= 2*N-2)
      for (int j = 0; j < N; j++)
        if (t - j >= 0 && t - j < N) r[DW*j +: DW] = m_w[t-j][j];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      m_busy  <= 1'b0;
      m_ca    <= 0;
      m_cw    <= 0;
      m_start <= -1;
      m_seen  <= -1;
    end else if (!m_busy) begin
      if (ld_valid && exp_ldr) begin
        for (int c = 0; c < N; c++) begin
          if (ld_sel) m_w[m_cw][c] <= ld_data[DW*c +: DW];
          else        m_a[m_ca][c] <= ld_data[DW*c +: DW];
        end
        if (ld_sel) m_cw <= m_cw + 1;
        else        m_ca <= m_ca + 1;
      end
      if (go && m_ca == N && m_cw == N) begin
        m_busy  <= 1'b1;
        m_start <= arr_ready ? cyc + 1 : -1;
        m_seen  <= -1;
      end
    end else begin
      if (m_start < 0 && arr_ready) m_start <= cyc + 1;
      if (arr_done && m_seen < 0)   m_seen  <= cyc;
      if (m_start >= 0 && m_seen >= 0 && cyc == done_at()) begin
        m_busy  <= 1'b0;
        m_ca    <= 0;
        m_cw    <= 0;
        m_start <= -1;
        m_seen  <= -1;
      end
    end
  end

  always @(negedge clk) begin
    int t;
    if (cyc > 0) begin
      t = (m_busy && m_start >= 0) ? cyc - m_start : -1;
      chk("cyc_busy",     busy,      m_busy);
      chk("cyc_start",    arr_start, m_busy && m_start >= 0 && cyc == m_start);
      chk("cyc_done",     done,      m_busy && m_start >= 0 && m_seen >= 0 && cyc == done_at());
      chk("cyc_a_out",    a_out,     lanes_a(t));
      chk("cyc_w_out",    w_out,     lanes_w(t));
      chk("cyc_ld_ready", ld_ready,  exp_ldr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW*N-1:0] row(input int base);
    logic [DW*N-1:0] r;
    logic [31:0]     v;
    for (int c = 0; c < N; c++) begin
      v = base + c;
      r[DW*c +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [DW*N-1:0] ident(input int r);
    logic [DW*N-1:0] v;
    v = '0;
    v[DW*r] = 1'b1;
    return v;
  endfunction

  task automatic beat(input logic sel, input logic [DW*N-1:0] d);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_data  = d;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic load_both(input int abase, input int wbase);
    for (int r = 0; r < N; r++) beat(1'b0, row(abase + N*r));
    for (int r = 0; r < N; r++) beat(1'b1, row(wbase + N*r));
  endtask

  initial begin
    rst = 1'b0; ld_valid = 1'b1; go = 1'b1; ld_sel = 1'b0;
    ld_data = '0; arr_ready = 1'b0; arr_done = 1'b0;

    // Reset held with load and go requests active
    step(); step();
    chk("rst_busy",  busy,      0);
    chk("rst_start", arr_start, 0);
    chk("rst_done",  done,      0);
    chk("rst_a_out", a_out,     0);
    chk("rst_w_out", w_out,     0);
    rst = 1'b1; ld_valid = 1'b0; go = 1'b0;
    #1 chk("idle_ld_ready", ld_ready, 1);
    step();

    // Early go after three A rows is ignored
    beat(1'b0, row(1)); beat(1'b0, row(5)); beat(1'b0, row(9));
    go = 1'b1; step(); go = 1'b0;
    chk("early_go_busy", busy, 0);
    beat(1'b0, row(13));

    // A is full: further A beats refused, W beats still accepted
    ld_valid = 1'b1; ld_sel = 1'b0; ld_data = row(200);
    #1 chk("ovf_a_ld_ready", ld_ready, 0);
    ld_sel = 1'b1;
    #1 chk("w_ld_ready", ld_ready, 1);
    ld_valid = 1'b0;
    step();
    for (int r = 0; r < N; r++) beat(1'b1, ident(r));

    // Skew with A = 1..16, W = identity
    arr_ready = 1'b1; go = 1'b1; step(); go = 1'b0;
    chk("skew_start", arr_start, 1);
    chk("skew_a_k0", a_out, 32'h0000_0001);
    chk("skew_w_k0", w_out, 32'h0000_0001);
    step();
    chk("skew_a_k1", a_out, 32'h0000_0502);
    chk("skew_w_k1", w_out, 32'h0000_0000);
    step();
    chk("skew_w_k2", w_out, 32'h0000_0100);
    step();
    chk("skew_a_k3", a_out, 32'h0D0A_0704);
    step();
    chk("skew_w_k4", w_out, 32'h0001_0000);
    step(); step();
    chk("skew_a_k6", a_out, 32'h1000_0000);
    chk("skew_w_k6", w_out, 32'h0100_0000);
    step();
    chk("drain_a_zero", a_out, 0);
    chk("drain_busy",   busy,  1);

    // arr_done three cycles into DRAIN
    step(); step();
    arr_done = 1'b1; step(); arr_done = 1'b0;
    chk("late_done", done, 1);
    step();
    chk("late_reload_ready", ld_ready, 1);
    chk("late_idle_busy",    busy,     0);

    // Backpressure on arr_ready, arr_done during STREAM
    load_both(8'h21, 8'h81);
    arr_ready = 1'b0; go = 1'b1; step(); go = 1'b0;
    repeat (5) begin
      chk("bp_busy",  busy,      1);
      chk("bp_start", arr_start, 0);
      chk("bp_a_out", a_out,     0);
      step();
    end
    arr_ready = 1'b1; step();
    chk("bp_start_after_ready", arr_start, 1);
    step(); step();
    arr_done = 1'b1; step(); arr_done = 1'b0;
    step(); step(); step(); step();
    chk("early_done_first_drain", done, 1);
    step();
    chk("early_reload_ready", ld_ready, 1);
    chk("early_idle_busy",    busy,     0);

    // Reset at stream index 3
    load_both(8'h31, 8'h91);
    go = 1'b1; step(); go = 1'b0;
    step(); step(); step();
    rst = 1'b0; step(); rst = 1'b1;
    chk("midrst_busy",  busy,  0);
    chk("midrst_a_out", a_out, 0);
    chk("midrst_w_out", w_out, 0);
    chk("midrst_done",  done,  0);
    step(); step(); step();

    // Normal operation after the aborted one
    load_both(8'h41, 8'hA1);
    go = 1'b1; step(); go = 1'b0;
    chk("post_start", arr_start, 1);
    repeat (2*N-1) step();
    arr_done = 1'b1; step(); arr_done = 1'b0;
    chk("post_done", done, 1);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
